adrv9001_tx_src: RTL and testbench

Transmit sample source stage for one ADRV9001 TX channel, sitting between the DMA AXI-Stream and the TX SSI serializer. It selects the per-channel sample source (DMA stream, constant register word, ramp test pattern or zero) and buffers DMA samples in a 4-entry FIFO. It gates output on the channel's SSI enable and counts DMA underflows. The register block supplies `data_src`, `const_data` and `ssi_en`.

---
 rtl/adrv9001_pkg.sv | 20 ++
 rtl/adrv9001_fifo_sync.sv | 74 +++++++
 rtl/adrv9001_tx_src.sv | 174 +++++++++++++++++
 tb/tb_adrv9001_tx_src.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/adrv9001_pkg.sv
// Shared encodings for the ADRV9001 TX sample source.
// Source selects, FSM states and the ramp word helper.
package adrv9001_pkg;

    localparam logic [1:0] SRC_DMA   = 2'd0;
    localparam logic [1:0] SRC_CONST = 2'd1;
    localparam logic [1:0] SRC_RAMP  = 2'd2;
    localparam logic [1:0] SRC_ZERO  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRIME,
        ST_RUN
    } state_e;

    function automatic logic [31:0] ramp_word(input logic [15:0] r);
        return {r, ~r};
    endfunction

endpackage

// File: rtl/adrv9001_fifo_sync.sv
// Single-clock sample FIFO with registered first-word-fall-through head.
// The head register always mirrors the oldest stored word.
module adrv9001_fifo_sync #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_q;
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    rd_d;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] head_q;
    logic [WIDTH-1:0] head_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign head_o  = head_q;

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o;

    // A word written where the read pointer lands becomes the new head directly.
    always_comb begin
        rd_d   = rd_q + PW'(pop_ok);
        head_d = mem_q[rd_d];
        if (push_ok && (wr_q == rd_d)) begin
            head_d = wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else if (flush_i) begin
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            head_q <= '0;
        end else begin
            wr_q   <= wr_q + PW'(push_ok);
            rd_q   <= rd_d;
            cnt_q  <= cnt_q + CW'(push_ok) - CW'(pop_ok);
            head_q <= head_d;
        end
    end

endmodule

// File: rtl/adrv9001_tx_src.sv
// ADRV9001 TX sample source: enable sync, run FSM, source mux,
// ramp generator and DMA underflow tracking in front of the SSI serializer.
module adrv9001_tx_src
    import adrv9001_pkg::*;
#(
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] RAMP_STEP  = 16'd1
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_areset,
    input  logic [1:0]  data_src,
    input  logic [31:0] const_data,
    input  logic        ssi_en,
    input  logic        underflow_clr,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        running,
    output logic        underflow,
    output logic [15:0] underflow_cnt
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          en_meta_q;
    logic          en_s_q;
    logic          en_prev_q;
    state_e        state_q;
    logic [1:0]    src_q;
    logic [15:0]   ramp_q;
    logic [15:0]   ramp_d;
    logic [31:0]   tdata_q;
    logic          tvalid_q;
    logic          uf_q;
    logic [15:0]   uf_cnt_q;

    logic          fifo_push;
    logic          fifo_pop;
    logic          fifo_flush;
    logic          fifo_full;
    logic          fifo_empty;
    logic [31:0]   fifo_head;
    logic [CW-1:0] fifo_cnt;

    logic          en_rise;
    logic          prime_done;
    logic          dma_take;
    logic          uf_ev;

    // Synchronizer and edge detector reset high: an enable held across
    // reset must not look like a fresh rising edge.
    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            en_meta_q <= 1'b1;
            en_s_q    <= 1'b1;
            en_prev_q <= 1'b1;
        end else begin
            en_meta_q <= ssi_en;
            en_s_q    <= en_meta_q;
            en_prev_q <= en_s_q;
        end
    end

    assign en_rise    = en_s_q && !en_prev_q;
    assign prime_done = (fifo_cnt == CW'(FIFO_DEPTH));
    assign dma_take   = (state_q == ST_RUN) && (src_q == SRC_DMA)
                        && en_s_q && m_axis_tready;
    assign uf_ev      = dma_take && fifo_empty;
    assign ramp_d     = ramp_q + RAMP_STEP;

    assign s_axis_tready = !fifo_full && ((state_q == ST_PRIME)
                           || ((state_q == ST_RUN) && (src_q == SRC_DMA)));
    assign fifo_push  = s_axis_tvalid && s_axis_tready;
    assign fifo_flush = (state_q == ST_IDLE);
    assign fifo_pop   = ((state_q == ST_PRIME) && en_s_q && prime_done)
                        || (dma_take && !fifo_empty);

    adrv9001_fifo_sync #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk_i   (s_axis_aclk),
        .rst_i   (s_axis_areset),
        .flush_i (fifo_flush),
        .push_i  (fifo_push),
        .wdata_i (s_axis_tdata),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt)
    );

    always_ff @(posedge s_axis_aclk or posedge s_axis_areset) begin
        if (s_axis_areset) begin
            state_q  <= ST_IDLE;
            src_q    <= SRC_DMA;
            ramp_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            uf_q     <= 1'b0;
            uf_cnt_q <= '0;
        end else begin
            if (underflow_clr) begin
                uf_q     <= 1'b0;
                uf_cnt_q <= '0;
            end else if (uf_ev) begin
                uf_q <= 1'b1;
                if (uf_cnt_q != 16'hFFFF) begin
                    uf_cnt_q <= uf_cnt_q + 16'd1;
                end
            end

            unique case (state_q)
                ST_IDLE: begin
                    tvalid_q <= 1'b0;
                    tdata_q  <= '0;
                    if (en_rise) begin
                        src_q  <= data_src;
                        ramp_q <= '0;
                        if (data_src == SRC_DMA) begin
                            state_q <= ST_PRIME;
                        end else begin
                            state_q  <= ST_RUN;
                            tvalid_q <= 1'b1;
                            unique case (data_src)
                                SRC_CONST: tdata_q <= const_data;
                                SRC_RAMP:  tdata_q <= ramp_word(16'h0000);
                                default:   tdata_q <= '0;
                            endcase
                        end
                    end
                end
                ST_PRIME: begin
                    if (!en_s_q) begin
                        state_q <= ST_IDLE;
                    end else if (prime_done) begin
                        state_q  <= ST_RUN;
                        tvalid_q <= 1'b1;
                        tdata_q  <= fifo_head;
                    end
                end
                ST_RUN: begin
                    if (!en_s_q) begin
                        state_q  <= ST_IDLE;
                        tvalid_q <= 1'b0;
                        tdata_q  <= '0;
                    end else if (m_axis_tready) begin
                        unique case (src_q)
                            SRC_DMA:   tdata_q <= fifo_empty ? '0 : fifo_head;
                            SRC_CONST: tdata_q <= const_data;
                            SRC_RAMP: begin
                                ramp_q  <= ramp_d;
                                tdata_q <= ramp_word(ramp_d);
                            end
                            default:   tdata_q <= '0;
                        endcase
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign running       = (state_q == ST_RUN);
    assign underflow     = uf_q;
    assign underflow_cnt = uf_cnt_q;

endmodule

// File: tb/tb_adrv9001_tx_src.sv
// Directed bench for adrv9001_tx_src: reset, const, ramp wrap,
// DMA prime/run, underflow and disable/source-change behaviour.
module tb_adrv9001_tx_src;

    logic        clk;
    logic        rst;
    logic [1:0]  data_src;
    logic [31:0] const_data;
    logic        ssi_en;
    logic        underflow_clr;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        running;
    logic        underflow;
    logic [15:0] underflow_cnt;

    int checks = 0;
    int failures = 0;

    adrv9001_tx_src #(
        .FIFO_DEPTH (4),
        .RAMP_STEP  (16'd1)
    ) dut (
        .s_axis_aclk   (clk),
        .s_axis_areset (rst),
        .data_src      (data_src),
        .const_data    (const_data),
        .ssi_en        (ssi_en),
        .underflow_clr (underflow_clr),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .running       (running),
        .underflow     (underflow),
        .underflow_cnt (underflow_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance n cycles; the DMA source steps its counter on each accepted word.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            logic acc;
            acc = s_axis_tready && s_axis_tvalid;
            @(posedge clk);
            #1;
            if (acc) s_axis_tdata = s_axis_tdata + 32'd1;
        end
    endtask

    initial begin
        logic [15:0] r;
        logic [31:0] w65536;
        logic [31:0] w65537;
        logic [31:0] expv;
        int          bad;

        rst           = 1'b1;
        data_src      = 2'd0;
        const_data    = 32'h0;
        ssi_en        = 1'b0;
        underflow_clr = 1'b0;
        s_axis_tdata  = 32'h0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b0;

        cyc(2);
        chk("rst_s_tready", 32'(s_axis_tready), 32'd0);
        chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("rst_m_tdata", m_axis_tdata, 32'h0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_underflow", 32'(underflow), 32'd0);
        chk("rst_uf_cnt", 32'(underflow_cnt), 32'd0);
        rst = 1'b0;
        cyc(4);

        // Constant source
        data_src      = 2'd1;
        const_data    = 32'h12345678;
        m_axis_tready = 1'b1;
        ssi_en        = 1'b1;
        cyc(2);
        chk("const_tvalid_early", 32'(m_axis_tvalid), 32'd0);
        cyc(1);
        chk("const_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("const_data0", m_axis_tdata, 32'h12345678);
        chk("const_running", 32'(running), 32'd1);
        const_data = 32'hABCD1234;
        cyc(1);
        chk("const_follow", m_axis_tdata, 32'hABCD1234);
        data_src = 2'd3;
        cyc(2);
        chk("src_change_in_run", m_axis_tdata, 32'hABCD1234);

        // Disable, then re-enable with zero source
        ssi_en = 1'b0;
        cyc(2);
        chk("dis_tvalid_still", 32'(m_axis_tvalid), 32'd1);
        cyc(1);
        chk("dis_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("dis_running", 32'(running), 32'd0);
        ssi_en = 1'b1;
        cyc(3);
        chk("zero_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("zero_data", m_axis_tdata, 32'h0);
        ssi_en = 1'b0;
        cyc(3);

        // Ramp with wrap
        data_src = 2'd2;
        ssi_en   = 1'b1;
        cyc(3);
        chk("ramp_w1", m_axis_tdata, 32'h0000FFFF);
        r      = 16'h0000;
        bad    = 0;
        w65536 = 32'h0;
        for (int i = 2; i <= 65537; i++) begin
            cyc(1);
            r = r + 16'd1;
            if (m_axis_tdata !== {r, ~r}) bad++;
            if (i == 65536) w65536 = m_axis_tdata;
        end
        w65537 = m_axis_tdata;
        chk("ramp_seq_errors", 32'(bad), 32'd0);
        chk("ramp_w65536", w65536, 32'hFFFF0000);
        chk("ramp_w65537", w65537, 32'h0000FFFF);
        m_axis_tready = 1'b0;
        cyc(5);
        chk("ramp_hold", m_axis_tdata, 32'h0000FFFF);
        m_axis_tready = 1'b1;
        cyc(1);
        chk("ramp_resume", m_axis_tdata, 32'h0001FFFE);
        ssi_en = 1'b0;
        cyc(3);

        // DMA prime and run
        data_src      = 2'd0;
        s_axis_tdata  = 32'd1;
        s_axis_tvalid = 1'b1;
        ssi_en        = 1'b1;
        cyc(7);
        chk("dma_prime_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("dma_prime_full", 32'(s_axis_tready), 32'd0);
        cyc(1);
        chk("dma_run_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("dma_first", m_axis_tdata, 32'd1);
        expv = 32'd1;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            expv = expv + 32'd1;
            if (m_axis_tdata !== expv) bad++;
        end
        chk("dma_seq_errors", 32'(bad), 32'd0);
        chk("dma_last", m_axis_tdata, 32'd21);
        chk("dma_s_tready", 32'(s_axis_tready), 32'd1);

        // Underflow
        s_axis_tvalid = 1'b0;
        cyc(3);
        chk("uf_drain", m_axis_tdata, 32'd24);
        chk("uf_none_yet", 32'(underflow), 32'd0);
        cyc(1);
        chk("uf_data", m_axis_tdata, 32'h0);
        chk("uf_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("uf_flag", 32'(underflow), 32'd1);
        chk("uf_cnt1", 32'(underflow_cnt), 32'd1);
        cyc(2);
        chk("uf_cnt3", 32'(underflow_cnt), 32'd3);
        underflow_clr = 1'b1;
        cyc(1);
        chk("uf_clr_flag", 32'(underflow), 32'd0);
        chk("uf_clr_cnt", 32'(underflow_cnt), 32'd0);
        underflow_clr = 1'b0;
        cyc(1);
        chk("uf_again_flag", 32'(underflow), 32'd1);
        chk("uf_again_cnt", 32'(underflow_cnt), 32'd1);

        // Asynchronous reset mid-run
        rst = 1'b1;
        #1;
        chk("arst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("arst_m_tdata", m_axis_tdata, 32'h0);
        chk("arst_running", 32'(running), 32'd0);
        chk("arst_underflow", 32'(underflow), 32'd0);
        chk("arst_uf_cnt", 32'(underflow_cnt), 32'd0);
        chk("arst_s_tready", 32'(s_axis_tready), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(6);
        chk("post_rst_idle_tvalid", 32'(m_axis_tvalid), 32'd0);
        chk("post_rst_idle_running", 32'(running), 32'd0);
        chk("post_rst_idle_tready", 32'(s_axis_tready), 32'd0);
        ssi_en   = 1'b0;
        data_src = 2'd1;
        cyc(3);
        ssi_en = 1'b1;
        cyc(2);
        chk("restart_tvalid_early", 32'(m_axis_tvalid), 32'd0);
        cyc(1);
        chk("restart_tvalid", 32'(m_axis_tvalid), 32'd1);
        chk("restart_data", m_axis_tdata, 32'hABCD1234);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
